// File: rtl/sobel_mag.sv
// Sobel edge-magnitude stage: |gx|+|gy| saturated to WIDTH_P bits, border-masked, two-stage valid/ready pipeline.
// Optional feature: define SOBEL_MAG_THRESH_EN to add thresh_i and produce a binary edge map.
module sobel_mag #(
    parameter int WIDTH_P  = 8,
    parameter int DEPTH_P  = 16,
    parameter int HEIGHT_P = 16
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic signed [2*WIDTH_P-1:0]   gx_i,
    input  logic signed [2*WIDTH_P-1:0]   gy_i,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic [WIDTH_P-1:0]            data_o,
    output logic                          sof_o,
    output logic                          eol_o
`ifdef SOBEL_MAG_THRESH_EN
    ,
    input  logic [WIDTH_P-1:0]            thresh_i
`endif
);

    localparam int GW    = 2 * WIDTH_P;
    localparam int SW    = GW + 1;
    localparam int COL_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int ROW_W = (HEIGHT_P > 1) ? $clog2(HEIGHT_P) : 1;

    // The most negative input has no positive twin, so it clamps to the largest positive value.
    function automatic logic [GW-1:0] abs_f(input logic [GW-1:0] x);
        logic [GW-1:0] r;
        if (x == {1'b1, {(GW-1){1'b0}}}) begin
            r = {1'b0, {(GW-1){1'b1}}};
        end else if (x[GW-1]) begin
            r = ~x + {{(GW-1){1'b0}}, 1'b1};
        end else begin
            r = x;
        end
        return r;
    endfunction

    function automatic logic [WIDTH_P-1:0] sat_f(input logic [SW-1:0] s);
        logic [WIDTH_P-1:0] r;
        if (s > {{(SW-WIDTH_P){1'b0}}, {WIDTH_P{1'b1}}}) begin
            r = {WIDTH_P{1'b1}};
        end else begin
            r = s[WIDTH_P-1:0];
        end
        return r;
    endfunction

    logic [COL_W-1:0]   col_r, s1_col_r;
    logic [ROW_W-1:0]   row_r, s1_row_r;
    logic               s1_valid_r, s2_valid_r;
    logic [GW-1:0]      s1_ax_r, s1_ay_r;
    logic [WIDTH_P-1:0] data_r;
    logic               sof_r, eol_r;

    logic               in_hs_s, s1_moves_s, s2_moves_s, s2_load_s;
    logic               col_last_s, row_last_s, border_s, sof_s, eol_s;
    logic [SW-1:0]      sum_s;
    logic [WIDTH_P-1:0] mag_s, pix_s;

    // Handshake network and the S1 -> S2 datapath.
    always_comb begin
        s2_moves_s = s2_valid_r & ready_i;
        s2_load_s  = ~s2_valid_r | s2_moves_s;
        s1_moves_s = s1_valid_r & s2_load_s;
        ready_o    = ~s1_valid_r | s1_moves_s;
        in_hs_s    = valid_i & ready_o;
        col_last_s = (col_r == COL_W'(DEPTH_P - 1));
        row_last_s = (row_r == ROW_W'(HEIGHT_P - 1));
        sum_s      = {1'b0, s1_ax_r} + {1'b0, s1_ay_r};
        mag_s      = sat_f(sum_s);
        border_s   = ({{(32-COL_W){1'b0}}, s1_col_r} < 32'd2) ||
                     ({{(32-ROW_W){1'b0}}, s1_row_r} < 32'd2);
        sof_s      = (s1_col_r == {COL_W{1'b0}}) && (s1_row_r == {ROW_W{1'b0}});
        eol_s      = (s1_col_r == COL_W'(DEPTH_P - 1));
`ifdef SOBEL_MAG_THRESH_EN
        if (mag_s > thresh_i) begin
            pix_s = {WIDTH_P{1'b1}};
        end else begin
            pix_s = {WIDTH_P{1'b0}};
        end
`else
        pix_s = mag_s;
`endif
        if (border_s) begin
            pix_s = {WIDTH_P{1'b0}};
        end else begin
            pix_s = pix_s;
        end
    end

    // Raster position of the next accepted beat.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (in_hs_s) begin
            if (col_last_s) begin
                col_r <= {COL_W{1'b0}};
                row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
        end else begin
            col_r <= col_r;
        end
    end

    // Stage 1: absolute gradients tagged with their position.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid_r <= 1'b0;
            s1_ax_r    <= {GW{1'b0}};
            s1_ay_r    <= {GW{1'b0}};
            s1_col_r   <= {COL_W{1'b0}};
            s1_row_r   <= {ROW_W{1'b0}};
        end else if (in_hs_s) begin
            s1_valid_r <= 1'b1;
            s1_ax_r    <= abs_f(gx_i);
            s1_ay_r    <= abs_f(gy_i);
            s1_col_r   <= col_r;
            s1_row_r   <= row_r;
        end else if (s1_moves_s) begin
            s1_valid_r <= 1'b0;
        end else begin
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: output register; sideband is cleared when the stage empties.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s2_valid_r <= 1'b0;
            data_r     <= {WIDTH_P{1'b0}};
            sof_r      <= 1'b0;
            eol_r      <= 1'b0;
        end else if (s1_moves_s) begin
            s2_valid_r <= 1'b1;
            data_r     <= pix_s;
            sof_r      <= sof_s;
            eol_r      <= eol_s;
        end else if (s2_moves_s) begin
            s2_valid_r <= 1'b0;
            data_r     <= {WIDTH_P{1'b0}};
            sof_r      <= 1'b0;
            eol_r      <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    assign valid_o = s2_valid_r;
    assign data_o  = data_r;
    assign sof_o   = sof_r;
    assign eol_o   = eol_r;

endmodule

// File: tb/tb_sobel_mag.sv
// Randomized self-checking bench for sobel_mag against a raster-position reference model.
module tb_sobel_mag;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int H  = 16;
    localparam int GW = 2 * W;

    logic                 clk_i = 1'b0;
    logic                 rstn_i = 1'b0;
    logic                 valid_i = 1'b0;
    logic                 ready_o;
    logic signed [GW-1:0] gx_i = '0;
    logic signed [GW-1:0] gy_i = '0;
    logic                 valid_o;
    logic                 ready_i = 1'b1;
    logic [W-1:0]         data_o;
    logic                 sof_o;
    logic                 eol_o;
    logic [W-1:0]         thresh = 8'd50;

    sobel_mag #(.WIDTH_P(W), .DEPTH_P(D), .HEIGHT_P(H)) dut (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .gx_i    (gx_i),
        .gy_i    (gy_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .sof_o   (sof_o),
        .eol_o   (eol_o)
`ifdef SOBEL_MAG_THRESH_EN
        ,
        .thresh_i(thresh)
`endif
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;
    logic [W+1:0] exp_q[$];
    int tb_col = 0;
    int tb_row = 0;
    logic stall_prev = 1'b0;
    logic [W+1:0] prev_out = '0;
    logic last_valid = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Expected {sof, eol, pixel} for a gradient pair at raster (r, c).
    function automatic logic [W+1:0] model(input int gx, input int gy, input int r, input int c);
        int lim, ax, ay, mag, pix;
        lim = 1 << (GW - 1);
        ax  = (gx == -lim) ? lim - 1 : ((gx < 0) ? -gx : gx);
        ay  = (gy == -lim) ? lim - 1 : ((gy < 0) ? -gy : gy);
        mag = ax + ay;
        if (mag > (1 << W) - 1) mag = (1 << W) - 1;
`ifdef SOBEL_MAG_THRESH_EN
        pix = (mag > int'(thresh)) ? (1 << W) - 1 : 0;
`else
        pix = mag;
`endif
        if (r < 2 || c < 2) pix = 0;
        return {(r == 0 && c == 0), (c == D - 1), W'(pix)};
    endfunction

    task automatic step(input logic v, input logic signed [GW-1:0] gx, input logic signed [GW-1:0] gy,
                        input logic rdy, output logic acc);
        logic [W+1:0] e;
        @(negedge clk_i);
        valid_i = v;
        gx_i    = gx;
        gy_i    = gy;
        ready_i = rdy;
        #1;
        last_valid = valid_o;
        if (stall_prev) begin
            check_eq("hold_valid", valid_o, 1);
            check_eq("hold_out", {sof_o, eol_o, data_o}, prev_out);
        end
        check_eq("ready_o", ready_o, !(exp_q.size() == 2 && !rdy));
        if (!valid_o) check_eq("idle_sideband", {sof_o, eol_o}, 0);
        if (valid_o && rdy) begin
            if (exp_q.size() == 0) begin
                check_eq("dup_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("data_o", data_o, e[W-1:0]);
                check_eq("sof_o", sof_o, e[W+1]);
                check_eq("eol_o", eol_o, e[W]);
            end
        end
        acc = v && ready_o;
        if (acc) begin
            exp_q.push_back(model(int'(gx), int'(gy), tb_row, tb_col));
            tb_col++;
            if (tb_col == D) begin
                tb_col = 0;
                tb_row = (tb_row == H - 1) ? 0 : tb_row + 1;
            end
        end
        stall_prev = valid_o && !rdy;
        prev_out   = {sof_o, eol_o, data_o};
    endtask

    task automatic send(input logic signed [GW-1:0] gx, input logic signed [GW-1:0] gy, input bit rnd);
        logic acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 100) begin
            step(1'b1, gx, gy, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            n++;
        end
        if (!acc) check_eq("send_timeout", 0, 1);
    endtask

    task automatic drain(input bit rnd);
        logic acc;
        int n;
        n = 0;
        while ((exp_q.size() != 0 || last_valid) && n < 200) begin
            step(1'b0, '0, '0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, acc);
            n++;
        end
        check_eq("drain_left", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i  = 1'b0;
        valid_i = 1'b0;
        #1;
        check_eq("rst_valid_o", valid_o, 0);
        check_eq("rst_ready_o", ready_o, 1);
        check_eq("rst_outs", {sof_o, eol_o, data_o}, 0);
        repeat (2) @(negedge clk_i);
        rstn_i = 1'b1;
        exp_q.delete();
        tb_col = 0;
        tb_row = 0;
        stall_prev = 1'b0;
        last_valid = 1'b0;
    endtask

    function automatic logic signed [GW-1:0] rnd_grad();
        logic signed [GW-1:0] g;
        if ($urandom_range(0, 3) == 0) g = GW'($urandom);
        else g = GW'($urandom_range(0, 200)) - 16'sd100;
        return g;
    endfunction

    initial begin
        logic acc;
        do_reset();

        // Latency and the first interior pixel at (2,2).
        for (int i = 0; i < 2 * D + 2; i++) send(16'sd0, 16'sd0, 1'b0);
        drain(1'b0);
        step(1'b1, -16'sd3, 16'sd4, 1'b1, acc);
        check_eq("lat_accept", acc, 1);
        step(1'b0, '0, '0, 1'b1, acc);
        check_eq("lat_cycle1", last_valid, 0);
        step(1'b0, '0, '0, 1'b1, acc);
        check_eq("lat_cycle2", last_valid, 1);
        check_eq("lat_data", data_o, 7);

        // Saturation and abs corner cases at interior pixels.
        send(16'sd200, -16'sd100, 1'b0);
        send(-16'sd32768, 16'sd0, 1'b0);
        send(-16'sd32768, -16'sd32768, 1'b0);
        send(16'sd0, 16'sd0, 1'b0);
        send(16'sd25, 16'sd25, 1'b0);
        send(16'sd25, -16'sd26, 1'b0);
        drain(1'b0);

        // Full frame plus the first beat of the next.
        do_reset();
        for (int i = 0; i < D * H + 1; i++) send(16'sd10, 16'sd10, 1'b0);
        drain(1'b0);

        // Random data with random backpressure.
        do_reset();
        for (int i = 0; i < 600; i++) send(rnd_grad(), rnd_grad(), 1'b1);
        drain(1'b1);

        // Reset mid-frame, then a fresh frame start.
        do_reset();
        for (int i = 0; i < 37; i++) send(rnd_grad(), rnd_grad(), 1'b1);
        do_reset();
        for (int i = 0; i < 40; i++) send(16'sd10, 16'sd10, 1'b0);
        drain(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sobel_mag.md
SOBEL_MAG -- requirements
Module: sobel_mag

Interface
REQ-001 SHALL have parameter WIDTH_P, default 8: output pixel width; gradient inputs are 2*WIDTH_P bits.
REQ-002 SHALL have parameter DEPTH_P, default 16: pixels per image row.
REQ-003 SHALL have parameter HEIGHT_P, default 16: rows per frame.
REQ-004 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn_i  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port valid_i  input  1  gx_i/gy_i valid.
REQ-007 SHALL have port ready_o  output  1  block accepts gx_i/gy_i this cycle.
REQ-008 SHALL have port gx_i  input  2*WIDTH_P  signed horizontal gradient, one per raster pixel.
REQ-009 SHALL have port gy_i  input  2*WIDTH_P  signed vertical gradient, one per raster pixel.
REQ-010 SHALL have port valid_o  output  1  data_o/sof_o/eol_o valid.
REQ-011 SHALL have port ready_i  input  1  downstream accepts the output beat.
REQ-012 SHALL have port data_o  output  WIDTH_P  edge magnitude pixel.
REQ-013 SHALL have port sof_o  output  1  beat is pixel (row 0, col 0) of a frame.
REQ-014 SHALL have port eol_o  output  1  beat is the last pixel of a row (col DEPTH_P-1).

Function
REQ-015 SHALL transfer an input beat only when valid_i and ready_o are both high, and an output beat only when valid_o and ready_i are both high.
REQ-016 SHALL be a two-stage registered pipeline: S1 holds |gx|, |gy|, col, row; S2 holds the final pixel, sof, eol.
REQ-017 SHALL load each stage when that stage is empty or its content moves on this cycle; ready_o = ~S1_valid | S1_moves; S2 moves when valid_o & ready_i.
REQ-018 SHALL have 2-cycle latency from input handshake to valid_o with ready_i held high, and sustain one beat per cycle.
REQ-019 SHALL hold data_o, sof_o and eol_o stable while valid_o is high and ready_i is low; no beat is dropped or duplicated under any ready_i pattern.
REQ-020 SHALL compute |x| as the two's-complement absolute value; x = -2^(2*WIDTH_P-1) yields 2^(2*WIDTH_P-1)-1.
REQ-021 SHALL sum |gx|+|gy| at 2*WIDTH_P+1 bits unsigned without overflow, then saturate to 2^WIDTH_P-1.
REQ-022 SHALL keep col (0..DEPTH_P-1) and row (0..HEIGHT_P-1) counters that advance on each input handshake; col wraps to 0 and increments row; row wraps from HEIGHT_P-1 to 0.
REQ-023 SHALL force data_o to 0 for border pixels, col < 2 or row < 2, because the 3x3 window is incomplete there; sof_o/eol_o are unaffected by masking.
REQ-024 SHALL assert sof_o iff the beat's (row, col) = (0, 0) and eol_o iff col = DEPTH_P-1; both are 0 whenever valid_o is 0.
REQ-025 SHALL, on a simultaneous S2 output handshake and input handshake, complete both in the same cycle with no bubble.

Reset
REQ-026 SHALL on rstn_i low immediately clear both stage valids, col, row, data_o, sof_o and eol_o to 0, with valid_o = 0.
REQ-027 SHALL drive ready_o = 1 during and after reset, because S1 is empty.
REQ-028 SHALL discard in-flight beats on reset asserted mid-frame; the first beat after release is treated as (row 0, col 0).

Configuration
REQ-029 SHALL, with macro SOBEL_MAG_THRESH_EN defined, add port thresh_i  input  WIDTH_P, sampled at the S2 load, and output data_o = 2^WIDTH_P-1 if saturated magnitude > thresh_i else 0; border masking still applies.
REQ-030 SHALL, without SOBEL_MAG_THRESH_EN, omit thresh_i and output the saturated magnitude.

Verification
REQ-031 SHALL cover: reset, then gx=-3, gy=4 at (row 2, col 2), ready_i=1 -> data_o=7, valid_o 2 cycles after the handshake.
REQ-032 SHALL cover: WIDTH_P=8, gx=200, gy=-100 at an interior pixel -> data_o=255 (saturated); gx=-32768, gy=0 -> data_o=255.
REQ-033 SHALL cover: a full 16x16 frame of gx=gy=10 -> data_o=0 on rows 0-1 and cols 0-1, 20 elsewhere; sof_o on the 1st beat only; eol_o on every 16th beat; the 257th beat has sof_o=1.
REQ-034 SHALL cover: ready_i random 50% with valid_i continuous -> output sequence identical to the ready_i=1 run, outputs stable while stalled, ready_o low only when both stages are full and stalled.
REQ-035 SHALL cover: rstn_i pulsed low after 37 input beats -> valid_o drops immediately; the next frame starts at sof_o=1 with border masking from row 0.
REQ-036 SHALL cover: with SOBEL_MAG_THRESH_EN and thresh_i=50, interior magnitudes 50 and 51 -> data_o=0 and 255 respectively.
